// File: rtl/jk_ff_pkg.sv
// Shared types for the jk_ff register bank: the {j,k} command encoding,
// the reset value and the per-bit next-state rule.
package jk_ff_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_cmd_e;

  localparam logic JK_RESET_VAL = 1'b0;

  // An unknown command yields X so that bad j/k are visible downstream.
  function automatic logic jk_next(input jk_cmd_e cmd, input logic cur);
    logic nxt;
    case (cmd)
      JK_HOLD: nxt = cur;
      JK_CLR:  nxt = 1'b0;
      JK_SET:  nxt = 1'b1;
      JK_TOG:  nxt = ~cur;
      default: nxt = 1'bx;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Single-bit JK register with synchronous reset and an internal clock enable.
// Reset is evaluated before j/k, so X on j/k during reset never reaches q.
module jk_ff_cell
  import jk_ff_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic j,
  input  logic k,
  output logic q
);

  logic    q_q;
  logic    q_d;
  jk_cmd_e cmd;

  always_comb begin
    cmd = jk_cmd_e'({j, k});
    q_d = q_q;
    if (reset) begin
      q_d = JK_RESET_VAL;
    end else if (ce) begin
      q_d = jk_next(cmd, q_q);
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jk_ff.sv
// Bank of WIDTH independent JK flip-flops with complementary outputs.
// Optional clock-enable port ce is added when JK_FF_CE_EN is defined.
module jk_ff
  import jk_ff_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
`ifdef JK_FF_CE_EN
  ,
  input  logic             ce
`endif
);

  logic ce_int;

`ifdef JK_FF_CE_EN
  assign ce_int = ce;
`else
  assign ce_int = 1'b1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      jk_ff_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .ce    (ce_int),
        .j     (j[gi]),
        .k     (k[gi]),
        .q     (q[gi])
      );
    end
  endgenerate

  // qb is derived, never stored, so it cannot drift from q.
  assign qb = ~q;

endmodule

// File: tb/tb_jk_ff.sv
// Scoreboard bench for jk_ff (WIDTH=4): directed plan steps followed by random
// traffic; covers the ce port when JK_FF_CE_EN is defined.
module tb_jk_ff;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] q;
  logic [W-1:0] qb;
  logic         ce;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [W-1:0] exp;
    string        name;
  } txn_t;

  txn_t         sb[$];
  logic [W-1:0] model_q;

  jk_ff #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .j     (j),
    .k     (k),
    .q     (q),
    .qb    (qb)
`ifdef JK_FF_CE_EN
    ,
    .ce    (ce)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each bit follows the textbook JK table, reset first, then enable.
  function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input logic r,
                                              input logic [W-1:0] jv, input logic [W-1:0] kv,
                                              input logic cev);
    logic [W-1:0] nxt;
    for (int i = 0; i < W; i++) begin
      if (r)                nxt[i] = 1'b0;
      else if (!cev)        nxt[i] = cur[i];
      else if (jv[i] && kv[i]) nxt[i] = !cur[i];
      else if (jv[i])       nxt[i] = 1'b1;
      else if (kv[i])       nxt[i] = 1'b0;
      else                  nxt[i] = cur[i];
    end
    return nxt;
  endfunction

  task automatic step(input string name, input logic r, input logic [W-1:0] jv,
                      input logic [W-1:0] kv, input logic cev);
    txn_t t;
    @(negedge clk);
    reset = r;
    j     = jv;
    k     = kv;
    ce    = cev;
    model_q = model_next(model_q, r, jv, kv, cev);
    t.exp  = model_q;
    t.name = name;
    sb.push_back(t);
  endtask

  // Monitor: every rising edge produces a new q; compare it against the queue head.
  initial begin
    logic rst_at_edge;
    txn_t t;
    forever begin
      @(posedge clk);
      rst_at_edge = reset;
      #1;
      if (sb.size() > 0) begin
        t = sb.pop_front();
        tests_run++;
        if (q !== t.exp || qb !== ~t.exp) begin
          tests_failed++;
          $display("[TB] FAIL %s: q=%b qb=%b, expected q=%b qb=%b", t.name, q, qb, t.exp, ~t.exp);
        end else begin
          $display("[TB] ok   %s: q=%b qb=%b", t.name, q, qb);
        end
        if (!$isunknown(q)) begin
          tests_run++;
          if (qb !== ~q) begin
            tests_failed++;
            $display("[TB] FAIL complement: q=%b qb=%b, expected qb=%b", q, qb, ~q);
          end
        end
        if (rst_at_edge) begin
          tests_run++;
          if (q !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_clears: q=%b, expected %b", q, {W{1'b0}});
          end
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    j       = '0;
    k       = '0;
    ce      = 1'b1;
    model_q = '0;

    // Reset with unknown j/k, then a quiet edge.
    step("reset_jk_x", 1'b1, 'x, 'x, 1'b1);
    step("post_reset_hold", 1'b0, 4'b0000, 4'b0000, 1'b1);

    // One command per cycle on every bit.
    step("cmd_hold", 1'b0, 4'b0000, 4'b0000, 1'b1);
    step("cmd_clr", 1'b0, 4'b0000, 4'b1111, 1'b1);
    step("cmd_set", 1'b0, 4'b1111, 4'b0000, 1'b1);
    step("cmd_tog", 1'b0, 4'b1111, 4'b1111, 1'b1);

    // Divide-by-two run from q=0.
    for (int n = 0; n < 4; n++) step($sformatf("toggle_%0d", n), 1'b0, 4'b1111, 4'b1111, 1'b1);

    // Reset beats a set on the same edge; release evaluates j/k normally.
    step("prio_set", 1'b0, 4'b1111, 4'b0000, 1'b1);
    step("prio_reset_vs_set", 1'b1, 4'b1111, 4'b0000, 1'b1);
    step("prio_release_tog", 1'b0, 4'b1111, 4'b1111, 1'b1);

    // Independent mixed commands per bit.
    step("mix_reset", 1'b1, 4'b0000, 4'b0000, 1'b1);
    step("mix_cmds", 1'b0, 4'b1010, 4'b0110, 1'b1);
    step("mix_tog_all", 1'b0, 4'b1111, 4'b1111, 1'b1);

`ifdef JK_FF_CE_EN
    step("ce_set", 1'b0, 4'b1111, 4'b0000, 1'b1);
    step("ce_off_clr_ignored", 1'b0, 4'b0000, 4'b1111, 1'b0);
    step("ce_off_reset", 1'b1, 4'b0000, 4'b0000, 1'b0);
    step("ce_on_set", 1'b0, 4'b1111, 4'b0000, 1'b1);
`endif

    for (int n = 0; n < 200; n++) begin
      logic         r;
      logic         cev;
      logic [W-1:0] jv;
      logic [W-1:0] kv;
      r   = ($urandom_range(0, 15) == 0);
      jv  = W'($urandom);
      kv  = W'($urandom);
`ifdef JK_FF_CE_EN
      cev = ($urandom_range(0, 3) != 0);
`else
      cev = 1'b1;
`endif
      step($sformatf("rand_%0d", n), r, jv, kv, cev);
    end

    // Let the monitor drain; a stuck queue counts as a failure.
    for (int n = 0; n < 4 && sb.size() > 0; n++) @(negedge clk);
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d transactions left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
